// File: rtl/data_mem_resp_pkg.sv
// data_mem_resp_pkg: access-size encodings, responder states and byte-lane helpers
package data_mem_resp_pkg;
  localparam logic [1:0] MEM_SIZE_B = 2'd0;
  localparam logic [1:0] MEM_SIZE_H = 2'd1;
  localparam logic [1:0] MEM_SIZE_W = 2'd2;
  typedef enum logic [1:0] {IDLE, WAIT, RESP, DONE} state_t;
  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] a);
    return size == MEM_SIZE_B ? 4'b0001 << a : size == MEM_SIZE_H ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  endfunction
  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] d);
    return size == MEM_SIZE_B ? {4{d[7:0]}} : size == MEM_SIZE_H ? {2{d[15:0]}} : d;
  endfunction
endpackage

// File: rtl/data_mem_resp_ram_sp_be.sv
// ram_sp_be: single-port 32-bit RAM with byte enables and registered read
module ram_sp_be #(
  parameter int DEPTH = 1024,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH];
  // per-lane write, read-before-write registered read every cycle
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    rdata <= mem[addr];
  end
endmodule

// File: rtl/data_mem_resp.sv
// data_mem_resp: wait-stated data memory responder with byte lanes and error flagging
module data_mem_resp
  import data_mem_resp_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_2000,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ram_wr_en_i,
  input  logic [31:0] ram_wr_addr_i,
  input  logic [31:0] ram_wr_data_i,
  input  logic        ram_rd_en_i,
  input  logic [31:0] ram_rd_addr_i,
  input  logic [1:0]  ram_size_i,
  output logic [31:0] ram_rd_data_o,
  output logic        ram_ready_o,
  output logic        ram_err_o
);
  localparam int AW = $clog2(DEPTH_WORDS);
  state_t state, next;
  logic [3:0] cnt;
  logic is_wr, err, accept, we;
  logic [31:0] addr_q, data_q, in_addr, in_off, off, rdata, shifted, rd_val, rd_q;
  logic [1:0] size_q;
  logic [AW-1:0] ram_addr;
  // address decode, error checks and read lane extraction on the latched request
  always_comb begin
    accept = state == IDLE && (ram_wr_en_i || ram_rd_en_i);
    in_addr = ram_wr_en_i ? ram_wr_addr_i : ram_rd_addr_i;
    in_off = in_addr - BASE_ADDR;
    off = addr_q - BASE_ADDR;
    err = (size_q == MEM_SIZE_H && addr_q[0]) || (size_q == MEM_SIZE_W && addr_q[1:0] != 2'd0) ||
          size_q == 2'd3 || off >= 32'(DEPTH_WORDS * 4);
    ram_addr = state == IDLE ? AW'(in_off >> 2) : AW'(off >> 2);
    we = state == RESP && is_wr && !err && !rst_i;
    shifted = rdata >> {addr_q[1:0], 3'b000};
    rd_val = err ? 32'd0 : size_q == MEM_SIZE_B ? {24'd0, shifted[7:0]} :
             size_q == MEM_SIZE_H ? {16'd0, shifted[15:0]} : shifted;
    ram_ready_o = state == RESP;
    ram_err_o = state == RESP && err;
    ram_rd_data_o = state == RESP && !is_wr ? rd_val : rd_q;
  end
  // next state; DONE blocks a still-held request from being serviced again
  always_comb begin
    next = state;
    if (accept) next = WAIT_CYCLES == 0 ? RESP : WAIT;
    else if (state == WAIT && cnt <= 4'd1) next = RESP;
    else if (state == RESP) next = DONE;
    else if (state == DONE && !ram_wr_en_i && !ram_rd_en_i) next = IDLE;
  end
  // state, wait counter and held read data
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt <= 4'd0;
      rd_q <= 32'd0;
    end else begin
      state <= next;
      cnt <= accept ? 4'(WAIT_CYCLES) : state == WAIT ? cnt - 4'd1 : cnt;
      if (state == RESP && !is_wr) rd_q <= rd_val;
    end
  end
  // request capture; write wins when both enables are high
  always_ff @(posedge clk_i) begin
    if (accept) begin
      is_wr <= ram_wr_en_i;
      addr_q <= in_addr;
      data_q <= ram_wr_data_i;
      size_q <= ram_size_i;
    end
  end
  ram_sp_be #(.DEPTH(DEPTH_WORDS)) u_ram (
    .clk(clk_i),
    .we(we),
    .be(lane_be(size_q, addr_q[1:0])),
    .addr(ram_addr),
    .wdata(lane_data(size_q, data_q)),
    .rdata(rdata)
  );
endmodule

// File: tb/tb_data_mem_resp.sv
// tb_data_mem_resp: scoreboard bench for one-wait-state and zero-wait-state responders
module tb_data_mem_resp;
  logic clk = 0, rst = 0, wr = 0, rd = 0;
  logic [31:0] wa = 0, ra = 0, wd = 0;
  logic [1:0] size = 0;
  logic [31:0] rd1, rd0;
  logic rdy1, er1, rdy0, er0;
  int tests = 0, fails = 0;
  logic [33:0] sb[$];
  always #5 clk = ~clk;
  data_mem_resp #(.WAIT_CYCLES(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .ram_wr_en_i(wr), .ram_wr_addr_i(wa), .ram_wr_data_i(wd),
    .ram_rd_en_i(rd), .ram_rd_addr_i(ra), .ram_size_i(size),
    .ram_rd_data_o(rd1), .ram_ready_o(rdy1), .ram_err_o(er1));
  data_mem_resp #(.WAIT_CYCLES(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .ram_wr_en_i(wr), .ram_wr_addr_i(wa), .ram_wr_data_i(wd),
    .ram_rd_en_i(rd), .ram_rd_addr_i(ra), .ram_size_i(size),
    .ram_rd_data_o(rd0), .ram_ready_o(rdy0), .ram_err_o(er0));

  task automatic req(input string nm, input logic w, r, input logic [31:0] a_w, a_r, d,
                     input logic [1:0] sz, input logic [31:0] ed, input logic ee, cd, input int hold);
    logic [33:0] exp;
    logic got = 0, quiet = 1;
    int n = 0;
    sb.push_back({cd, ee, ed});
    exp = sb[0];
    @(negedge clk);
    wr = w; rd = r; wa = a_w; ra = a_r; wd = d; size = sz;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (rdy0) begin
        tests++;
        if (n !== 1 || er0 !== exp[32] || (exp[33] && rd0 !== exp[31:0])) begin
          fails++;
          $display("FAIL %s w0: lat=%0d data=%h err=%b, need lat=1 data=%h err=%b", nm, n, rd0, er0, exp[31:0], exp[32]);
        end
      end
      if (rdy1) begin
        got = 1;
        exp = sb.pop_front();
        tests++;
        if (n !== 2 || er1 !== exp[32] || (exp[33] && rd1 !== exp[31:0])) begin
          fails++;
          $display("FAIL %s w1: lat=%0d data=%h err=%b, need lat=2 data=%h err=%b", nm, n, rd1, er1, exp[31:0], exp[32]);
        end
      end
    end
    if (!got) begin
      void'(sb.pop_front());
      tests++; fails++;
      $display("FAIL %s timeout: no ready in 20 cycles, need ready", nm);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (rdy1 || er1 || rdy0 || er0) quiet = 0;
    end
    tests++;
    if (!quiet) begin
      fails++;
      $display("FAIL %s post-pulse: extra ready/err seen, need none", nm);
    end
    wr = 0; rd = 0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    tests++;
    if ({rdy1, er1, rd1, rdy0, er0, rd0} !== 68'd0) begin
      fails++;
      $display("FAIL reset: rdy1=%b er1=%b rd1=%h rdy0=%b er0=%b rd0=%h, need all 0", rdy1, er1, rd1, rdy0, er0, rd0);
    end
  endtask

  task automatic test_word;
    req("sw_2004", 1, 0, 32'h2004, 0, 32'hDEADBEEF, 2'd2, 0, 0, 0, 1);
    req("lw_2004", 0, 1, 0, 32'h2004, 0, 2'd2, 32'hDEADBEEF, 0, 1, 1);
    repeat (3) @(negedge clk);
    tests++;
    if (rd1 !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL rd_hold: rd_data=%h, need deadbeef", rd1);
    end
  endtask

  task automatic test_lanes;
    req("sb_2005", 1, 0, 32'h2005, 0, 32'h000000AA, 2'd0, 0, 0, 0, 1);
    req("lw_lane", 0, 1, 0, 32'h2004, 0, 2'd2, 32'hDEADAAEF, 0, 1, 1);
    req("lh_2006", 0, 1, 0, 32'h2006, 0, 2'd1, 32'h0000DEAD, 0, 1, 1);
    req("lb_2005", 0, 1, 0, 32'h2005, 0, 2'd0, 32'h000000AA, 0, 1, 1);
    req("sh_2006", 1, 0, 32'h2006, 0, 32'hFFFF1234, 2'd1, 0, 0, 0, 1);
    req("lw_sh", 0, 1, 0, 32'h2004, 0, 2'd2, 32'h1234AAEF, 0, 1, 1);
    req("lb_2007", 0, 1, 0, 32'h2007, 0, 2'd0, 32'h00000012, 0, 1, 1);
    req("lh_2004", 0, 1, 0, 32'h2004, 0, 2'd1, 32'h0000AAEF, 0, 1, 1);
  endtask

  task automatic test_errors;
    req("sw_2000", 1, 0, 32'h2000, 0, 32'h11111111, 2'd2, 0, 0, 0, 1);
    req("lw_mis", 0, 1, 0, 32'h2002, 0, 2'd2, 0, 1, 1, 1);
    req("sh_mis", 1, 0, 32'h2003, 0, 32'h0000FFFF, 2'd1, 0, 1, 0, 1);
    req("rd_sz3", 0, 1, 0, 32'h2000, 0, 2'd3, 0, 1, 1, 1);
    req("wr_sz3", 1, 0, 32'h2000, 0, 32'hFFFFFFFF, 2'd3, 0, 1, 0, 1);
    req("lw_keep", 0, 1, 0, 32'h2000, 0, 2'd2, 32'h11111111, 0, 1, 1);
    req("lw_2004k", 0, 1, 0, 32'h2004, 0, 2'd2, 32'h1234AAEF, 0, 1, 1);
  endtask

  task automatic test_range;
    req("sw_2ffc", 1, 0, 32'h2FFC, 0, 32'h22222222, 2'd2, 0, 0, 0, 1);
    req("sw_below", 1, 0, 32'h1FFC, 0, 32'h0, 2'd2, 0, 1, 0, 1);
    req("sw_above", 1, 0, 32'h3000, 0, 32'h0, 2'd2, 0, 1, 0, 1);
    req("lb_below", 0, 1, 0, 32'h1FFF, 0, 2'd0, 0, 1, 1, 1);
    req("lw_3000", 0, 1, 0, 32'h3000, 0, 2'd2, 0, 1, 1, 1);
    req("lw_2000r", 0, 1, 0, 32'h2000, 0, 2'd2, 32'h11111111, 0, 1, 1);
    req("lw_2ffcr", 0, 1, 0, 32'h2FFC, 0, 2'd2, 32'h22222222, 0, 1, 1);
  endtask

  task automatic test_back_to_back;
    req("sw_hold", 1, 0, 32'h200C, 0, 32'h0BADF00D, 2'd2, 0, 0, 0, 10);
    req("lw_hold", 0, 1, 0, 32'h200C, 0, 2'd2, 32'h0BADF00D, 0, 1, 10);
    req("wr_rd_both", 1, 1, 32'h2008, 32'h2004, 32'h55667788, 2'd2, 0, 0, 0, 1);
    req("lw_2008", 0, 1, 0, 32'h2008, 0, 2'd2, 32'h55667788, 0, 1, 1);
  endtask

  task automatic test_reset_wait;
    @(negedge clk);
    wr = 1; wa = 32'h2000; wd = 32'hCAFEF00D; size = 2'd2;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    wr = 0;
    tests++;
    if ({rdy1, er1, rdy0, er0} !== 4'd0) begin
      fails++;
      $display("FAIL rst_wait: rdy1=%b er1=%b rdy0=%b er0=%b, need 0", rdy1, er1, rdy0, er0);
    end
    tests++;
    if (rd1 !== 32'd0 || rd0 !== 32'd0) begin
      fails++;
      $display("FAIL rst_wait_data: rd1=%h rd0=%h, need 0", rd1, rd0);
    end
    rst = 0;
    @(negedge clk);
    req("lw_after_rst", 0, 1, 0, 32'h2000, 0, 2'd2, 32'h11111111, 0, 1, 1);
  endtask

  initial begin
    test_reset;
    test_word;
    test_lanes;
    test_errors;
    test_range;
    test_back_to_back;
    test_reset_wait;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
